// File: rtl/wbc_pkg.sv
// Shared definitions for the power-up / bus-init sequencer and the reset generator.
// Holds the sequencer state encoding and width helpers.
package wbc_pkg;

  typedef enum logic [2:0] {
    SEQ_HOLD   = 3'd0,
    SEQ_DEV    = 3'd1,
    SEQ_ACLO   = 3'd2,
    SEQ_RUN    = 3'd3,
    SEQ_SWINIT = 3'd4
  } seq_state_e;

  // Ceiling log2 with a floor of 1 bit, so a 0- or 1-valued range still gets a real vector.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((64'd1 << w) < 64'(value))) begin
      w++;
    end
    return w;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/wbc_seq_timer.sv
// Loadable down-counter with a terminal-count flag; holds at zero until reloaded.
module wbc_seq_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/wbc_init_seq.sv
// Power-up sequencer: releases device resets one at a time behind DCLO, then drops ACLO,
// and stretches CPU RESET instructions into fixed-width bus INIT pulses.
module wbc_init_seq
  import wbc_pkg::*;
#(
  parameter int unsigned NDEV          = 4,
  parameter int unsigned READY_TIMEOUT = 1023,
  parameter int unsigned ACLO_DELAY    = 7,    // must be >= 1
  parameter int unsigned INIT_WIDTH    = 16    // must be >= 1
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            dclo_in,
  input  logic            cpu_reset_req,
  input  logic [NDEV-1:0] dev_ready,
  output logic [NDEV-1:0] dev_rst,
  output logic            sys_aclo,
  output logic            bus_init,
  output logic            seq_busy,
  output logic [NDEV-1:0] seq_fault
);

  localparam int unsigned MaxCount = max3(READY_TIMEOUT, ACLO_DELAY, INIT_WIDTH);
  localparam int unsigned CntW     = log2(MaxCount + 1);
  localparam int unsigned IdxW     = log2(NDEV);

  localparam logic [CntW-1:0] LdTimeout = CntW'(READY_TIMEOUT);
  localparam logic [CntW-1:0] LdAclo    = CntW'(ACLO_DELAY - 1);
  localparam logic [CntW-1:0] LdInit    = CntW'(INIT_WIDTH - 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NDEV - 1);

  seq_state_e      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [NDEV-1:0] fault_q, fault_d;
  logic [NDEV-1:0] dev_rst_q, dev_rst_d;
  logic            aclo_q, aclo_d;
  logic            init_q, init_d;
  logic            busy_q, busy_d;

  logic            tmr_load;
  logic [CntW-1:0] tmr_val;
  logic            tmr_tc;

  // One timer serves all three intervals; they never overlap by state.
  wbc_seq_timer #(
    .Width (CntW)
  ) u_timer (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fault_d  = fault_q;
    tmr_load = 1'b0;
    tmr_val  = LdTimeout;

    case (state_q)
      SEQ_HOLD: begin
        idx_d   = '0;
        fault_d = '0;
        if (!dclo_in) begin
          state_d  = SEQ_DEV;
          tmr_load = 1'b1;
          tmr_val  = LdTimeout;
        end
      end
      SEQ_DEV: begin
        // Ready wins a tie with the timeout, so the fault only sets without ready.
        if (dev_ready[idx_q] || tmr_tc) begin
          if (!dev_ready[idx_q]) fault_d[idx_q] = 1'b1;
          tmr_load = 1'b1;
          if (idx_q == LastIdx) begin
            state_d = SEQ_ACLO;
            tmr_val = LdAclo;
          end else begin
            idx_d   = idx_q + 1'b1;
            tmr_val = LdTimeout;
          end
        end
      end
      SEQ_ACLO: begin
        if (tmr_tc) state_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        if (cpu_reset_req) begin
          state_d  = SEQ_SWINIT;
          tmr_load = 1'b1;
          tmr_val  = LdInit;
        end
      end
      SEQ_SWINIT: begin
        if (tmr_tc) state_d = SEQ_RUN;
      end
      default: state_d = SEQ_HOLD;
    endcase

    if (dclo_in) begin
      state_d = SEQ_HOLD;
      idx_d   = '0;
      fault_d = '0;
    end
  end

  // Outputs are decoded from the next state so every output is a flop.
  always_comb begin
    dev_rst_d = '0;
    aclo_d    = 1'b0;
    init_d    = 1'b0;
    busy_d    = 1'b1;

    case (state_d)
      SEQ_HOLD: begin
        dev_rst_d = '1;
        aclo_d    = 1'b1;
        init_d    = 1'b1;
      end
      SEQ_DEV: begin
        for (int i = 0; i < int'(NDEV); i++) begin
          dev_rst_d[i] = (i > int'(idx_d));
        end
        aclo_d = 1'b1;
        init_d = 1'b1;
      end
      SEQ_ACLO: begin
        aclo_d = 1'b1;
        init_d = 1'b1;
      end
      SEQ_RUN: begin
        busy_d = 1'b0;
      end
      SEQ_SWINIT: begin
        init_d = 1'b1;
      end
      default: begin
        dev_rst_d = '1;
        aclo_d    = 1'b1;
        init_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= SEQ_HOLD;
      idx_q     <= '0;
      fault_q   <= '0;
      dev_rst_q <= '1;
      aclo_q    <= 1'b1;
      init_q    <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fault_q   <= fault_d;
      dev_rst_q <= dev_rst_d;
      aclo_q    <= aclo_d;
      init_q    <= init_d;
      busy_q    <= busy_d;
    end
  end

  assign dev_rst   = dev_rst_q;
  assign sys_aclo  = aclo_q;
  assign bus_init  = init_q;
  assign seq_busy  = busy_q;
  assign seq_fault = fault_q;

endmodule

// File: tb/tb_wbc_init_seq.sv
// Bench for wbc_init_seq: each scenario queues the expected per-cycle output vector
// {dev_rst, sys_aclo, bus_init, seq_busy, seq_fault} and compares it after every edge.
module tb_wbc_init_seq;

  localparam int unsigned NDEV = 4;

  logic            sys_clk;
  logic            sys_rst;
  logic            dclo_in;
  logic            cpu_reset_req;
  logic [NDEV-1:0] dev_ready;
  logic [NDEV-1:0] dev_rst;
  logic            sys_aclo;
  logic            bus_init;
  logic            seq_busy;
  logic [NDEV-1:0] seq_fault;

  int checks;
  int failures;

  logic [10:0] exp_q[$];

  wbc_init_seq #(
    .NDEV          (NDEV),
    .READY_TIMEOUT (20),
    .ACLO_DELAY    (7),
    .INIT_WIDTH    (16)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .dclo_in       (dclo_in),
    .cpu_reset_req (cpu_reset_req),
    .dev_ready     (dev_ready),
    .dev_rst       (dev_rst),
    .sys_aclo      (sys_aclo),
    .bus_init      (bus_init),
    .seq_busy      (seq_busy),
    .seq_fault     (seq_fault)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [10:0] pack(input logic [3:0] rst, input logic aclo, input logic init,
                                       input logic busy, input logic [3:0] fault);
    return {rst, aclo, init, busy, fault};
  endfunction

  task automatic push_n(input int cnt, input logic [10:0] v);
    for (int i = 0; i < cnt; i++) exp_q.push_back(v);
  endtask

  task automatic test_reset();
    int n;
    logic [10:0] e, obs;
    push_n(3, pack(4'b1111, 1, 1, 1, 4'b0000));
    n = 0;
    while (exp_q.size() != 0) begin
      sys_rst = (n < 2);
      dclo_in = 1'b1;
      @(posedge sys_clk); #1;
      n++;
      e = exp_q.pop_front();
      obs = {dev_rst, sys_aclo, bus_init, seq_busy, seq_fault};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset cycle %0d got %b want %b", n, obs, e);
      end
    end
  endtask

  task automatic test_prompt();
    int n;
    logic [10:0] e, obs;
    push_n(1, pack(4'b1110, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b1100, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b1000, 1, 1, 1, 4'b0000));
    push_n(8, pack(4'b0000, 1, 1, 1, 4'b0000));
    push_n(2, pack(4'b0000, 0, 0, 0, 4'b0000));
    n = 0;
    while (exp_q.size() != 0) begin
      dclo_in   = 1'b0;
      dev_ready = 4'b1111;
      @(posedge sys_clk); #1;
      n++;
      e = exp_q.pop_front();
      obs = {dev_rst, sys_aclo, bus_init, seq_busy, seq_fault};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL prompt cycle %0d got %b want %b", n, obs, e);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [10:0] e, obs;
    push_n(1, pack(4'b1111, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b1110, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b1100, 1, 1, 1, 4'b0000));
    push_n(21, pack(4'b1000, 1, 1, 1, 4'b0000));
    push_n(8, pack(4'b0000, 1, 1, 1, 4'b0100));
    push_n(3, pack(4'b0000, 0, 0, 0, 4'b0100));
    n = 0;
    while (exp_q.size() != 0) begin
      dclo_in   = (n == 0);
      dev_ready = 4'b1011;
      @(posedge sys_clk); #1;
      n++;
      e = exp_q.pop_front();
      obs = {dev_rst, sys_aclo, bus_init, seq_busy, seq_fault};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL timeout cycle %0d got %b want %b", n, obs, e);
      end
    end
  endtask

  task automatic test_swinit();
    int n;
    logic [10:0] e, obs;
    push_n(16, pack(4'b0000, 0, 1, 1, 4'b0100));
    push_n(3, pack(4'b0000, 0, 0, 0, 4'b0100));
    n = 0;
    while (exp_q.size() != 0) begin
      dclo_in       = 1'b0;
      cpu_reset_req = (n == 0) || (n == 5);
      @(posedge sys_clk); #1;
      n++;
      e = exp_q.pop_front();
      obs = {dev_rst, sys_aclo, bus_init, seq_busy, seq_fault};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL swinit cycle %0d got %b want %b", n, obs, e);
      end
    end
    cpu_reset_req = 1'b0;
  endtask

  task automatic test_dclo_mid_seq();
    int n;
    logic [10:0] e, obs;
    push_n(1, pack(4'b1111, 1, 1, 1, 4'b0000));
    push_n(21, pack(4'b1110, 1, 1, 1, 4'b0000));
    push_n(3, pack(4'b1100, 1, 1, 1, 4'b0001));
    push_n(1, pack(4'b1111, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b1110, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b1100, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b1000, 1, 1, 1, 4'b0000));
    push_n(8, pack(4'b0000, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b0000, 0, 0, 0, 4'b0000));
    n = 0;
    while (exp_q.size() != 0) begin
      dclo_in   = (n == 0) || (n == 25);
      dev_ready = (n >= 26) ? 4'b1111 : 4'b0000;
      @(posedge sys_clk); #1;
      n++;
      e = exp_q.pop_front();
      obs = {dev_rst, sys_aclo, bus_init, seq_busy, seq_fault};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL dclo_mid_seq cycle %0d got %b want %b", n, obs, e);
      end
    end
  endtask

  task automatic test_dclo_mid_init();
    int n;
    logic [10:0] e, obs;
    push_n(3, pack(4'b0000, 0, 1, 1, 4'b0000));
    push_n(1, pack(4'b1111, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b1110, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b1100, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b1000, 1, 1, 1, 4'b0000));
    push_n(8, pack(4'b0000, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b0000, 0, 0, 0, 4'b0000));
    n = 0;
    while (exp_q.size() != 0) begin
      cpu_reset_req = (n == 0);
      dclo_in       = (n == 3);
      dev_ready     = 4'b1111;
      @(posedge sys_clk); #1;
      n++;
      e = exp_q.pop_front();
      obs = {dev_rst, sys_aclo, bus_init, seq_busy, seq_fault};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL dclo_mid_init cycle %0d got %b want %b", n, obs, e);
      end
    end
    cpu_reset_req = 1'b0;
  endtask

  task automatic test_tie();
    int n;
    logic [10:0] e, obs;
    push_n(1, pack(4'b1111, 1, 1, 1, 4'b0000));
    push_n(21, pack(4'b1110, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b1100, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b1000, 1, 1, 1, 4'b0000));
    push_n(8, pack(4'b0000, 1, 1, 1, 4'b0000));
    push_n(1, pack(4'b0000, 0, 0, 0, 4'b0000));
    n = 0;
    while (exp_q.size() != 0) begin
      dclo_in   = (n == 0);
      dev_ready = (n == 22) ? 4'b0001 : ((n > 22) ? 4'b1111 : 4'b0000);
      @(posedge sys_clk); #1;
      n++;
      e = exp_q.pop_front();
      obs = {dev_rst, sys_aclo, bus_init, seq_busy, seq_fault};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL tie cycle %0d got %b want %b", n, obs, e);
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    sys_rst       = 1'b1;
    dclo_in       = 1'b1;
    cpu_reset_req = 1'b0;
    dev_ready     = '0;
    test_reset();
    test_prompt();
    test_timeout();
    test_swinit();
    test_dclo_mid_seq();
    test_dclo_mid_init();
    test_tie();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wbc_init_seq.md
# wbc_init_seq

Power-up and bus-initialisation sequencer that sits directly behind the reset generator. It consumes the generator's DCLO output and releases per-device resets one device at a time, each gated by that device's ready handshake with a timeout. It then deasserts ACLO after a programmable delay, and it issues fixed-width bus INIT pulses when the CPU executes a software RESET.

## Interface
Parameters:
- `NDEV`, 4, number of sequenced device reset channels (1..8); channel 0 is released first.
- `READY_TIMEOUT`, 1023, maximum cycles to wait for `dev_ready[i]` before skipping that channel.
- `ACLO_DELAY`, 7, cycles from the last device release to ACLO deassertion.
- `INIT_WIDTH`, 16, width of the software INIT pulse, in cycles.

Ports:
- `sys_clk` in 1: processor clock; all logic is synchronous to its rising edge.
- `sys_rst` in 1: synchronous active-high reset.
- `dclo_in` in 1: DCLO from the reset generator, already in the `sys_clk` domain.
- `cpu_reset_req` in 1: one-cycle pulse from the CPU when it executes a RESET instruction.
- `dev_ready` in NDEV: per-device initialisation complete.
- `dev_rst` out NDEV: per-device reset, active high.
- `sys_aclo` out 1: ACLO to the CPU, active high.
- `bus_init` out 1: bus INIT, active high.
- `seq_busy` out 1: high in every state except S_RUN.
- `seq_fault` out NDEV: sticky timeout flags, one per channel.

## Operation
- Reset values (`sys_rst`=1): state S_HOLD, `dev_rst`=all ones, `sys_aclo`=1, `bus_init`=1, `seq_busy`=1, `seq_fault`=0, and all counters 0.
- The FSM states are S_HOLD, S_DEV, S_ACLO, S_RUN and S_SWINIT.
- **S_HOLD:** all outputs are held at their reset values, with `idx`=0.
  - When `dclo_in`=0, the FSM moves to S_DEV.
  - `seq_fault` is cleared on entry to S_HOLD.
- **S_DEV:**
  - On entry for channel `idx`, `dev_rst[idx]` is cleared. Channels already released stay released.
  - The wait counter counts from 0.
  - If `dev_ready[idx]`=1, or the counter reaches `READY_TIMEOUT`, the FSM advances. On a timeout it sets `seq_fault[idx]`.
  - After channel `NDEV-1` the FSM moves to S_ACLO; otherwise it increments `idx`.
  - If `dev_ready` and the timeout occur in the same cycle, `dev_ready` wins and no fault is set.
- **S_ACLO:** counts `ACLO_DELAY` cycles, then clears `sys_aclo` and `bus_init` and moves to S_RUN.
- **S_RUN:** all outputs are idle (`dev_rst`=0, `sys_aclo`=0, `bus_init`=0, `seq_busy`=0).
  - `cpu_reset_req`=1 moves the FSM to S_SWINIT.
- **S_SWINIT:** `bus_init`=1 for exactly `INIT_WIDTH` cycles, then the FSM returns to S_RUN.
  - `dev_rst` and `sys_aclo` stay at 0.
  - Any `cpu_reset_req` pulses that arrive during S_SWINIT are ignored; they are not queued.
- **DCLO priority:** `dclo_in`=1 in any state forces S_HOLD on the next edge. This overrides every other transition, including an abort mid-sequence or mid-INIT.
- **Counter widths:** each counter is clog2(parameter+1) bits. Counters never wrap; a counter holds at its terminal value until the state changes.

## Timing
- The edge at which `dclo_in` falls to 0 is E0:
  - Registered S_DEV is entered at E0+1.
  - `dev_rst[0]` drops at E0+1.
- A device ready at cycle T causes the next channel's `dev_rst` to drop at T+1.
- The last release at cycle T leads to `sys_aclo`/`bus_init` falling at T+1+`ACLO_DELAY`.
- All devices are ready immediately and `NDEV`=4 gives 4 + `ACLO_DELAY` + 1 cycles from E0 to S_RUN.
- `cpu_reset_req` at edge T:
  - `bus_init` rises at T+1 and falls at T+1+`INIT_WIDTH`.
  - `seq_busy` tracks `bus_init` exactly.
- `dclo_in` rising at edge T: all `dev_rst` bits, `sys_aclo` and `bus_init` are 1 after T+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `wbc_pkg`:
  - state encoding constants `SEQ_HOLD`, `SEQ_DEV`, `SEQ_ACLO`, `SEQ_RUN`, `SEQ_SWINIT`;
  - the `log2` width function, so it is shared with the reset generator.
- One natural sub-module, `wbc_seq_timer`: a loadable down-counter with a terminal-count flag. It is instantiated for the ready timeout, the ACLO delay and the INIT width. Alternatively, one shared instance can be used, since these intervals are mutually exclusive by state.

## Test plan
- **Power-up, prompt devices:** hold `sys_rst` for 2 cycles with `dclo_in`=1, then drop `dclo_in`, with `dev_ready` driven immediately, `NDEV`=4 and `ACLO_DELAY`=7.
  - -> `dev_rst` releases 0→1→2→3 on consecutive cycles;
  - -> `sys_aclo` falls 8 cycles after channel 3 is released;
  - -> `seq_fault`=0.
- **Channel timeout:** `dev_ready[2]` held at 0, `READY_TIMEOUT`=20.
  - -> channel 3 is released 21 cycles after channel 2;
  - -> `seq_fault`=4'b0100 and stays set in S_RUN.
- **Software INIT:** a single `cpu_reset_req` pulse in S_RUN, `INIT_WIDTH`=16.
  - -> `bus_init` is high for exactly 16 cycles;
  - -> `dev_rst`=0 and `sys_aclo`=0 throughout;
  - -> a second pulse at cycle 5 of INIT has no effect.
- **DCLO mid-sequence:** raise `dclo_in` while channel 1 is waiting.
  - -> the next cycle shows `dev_rst`=4'b1111, `sys_aclo`=1, `bus_init`=1 and `seq_fault` cleared;
  - -> on re-release the sequence restarts at channel 0.
- **DCLO mid-INIT:** raise `dclo_in` at INIT cycle 3.
  - -> S_HOLD next cycle with all resets asserted.
- **Ready/timeout tie:** `dev_ready[0]` rises on exactly the timeout cycle.
  - -> the FSM advances and `seq_fault[0]`=0.
